// File: rtl/delay_line_deframer.sv
// ============================================================================
// Module     : delay_line_deframer
// Description: Receives the start/data/stop serial frames that come back from
//              the delay line. Bytes go into a small FIFO with a valid/ready
//              output. Bad stop bits raise frame_err, and bytes dropped on a
//              full FIFO raise overflow. Defining the macro
//              DEFRAMER_MAJORITY_EN switches every bit decision to a 2-of-3
//              majority vote.
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module delay_line_deframer #(
  parameter int BIT_CYCLES = 154,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       frame_err,
  output logic       overflow,
  output logic       busy
);

  localparam int         PW       = $clog2(FIFO_DEPTH);
  localparam logic [15:0] BIT_LAST = 16'(BIT_CYCLES - 1);
`ifdef DEFRAMER_MAJORITY_EN
  // The vote window ends one cycle past the nominal midpoint.
  localparam logic [15:0] START_PT = 16'(BIT_CYCLES / 2 + 1);
`else
  localparam logic [15:0] START_PT = 16'(BIT_CYCLES / 2);
`endif

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    START    = 3'd1,
    DATA     = 3'd2,
    STOP     = 3'd3,
    WAIT_LOW = 3'd4
  } state_t;

  state_t      state, state_n;
  logic [15:0] cnt, cnt_n;
  logic [2:0]  idx, idx_n;
  logic [7:0]  shift, shift_n;
  logic        err_n, push;
  logic        sync1, sync2, sync_prev;
  logic        rise, sample_bit;

  // Two-flop synchronizer plus the delayed copy used for edge detection.
  // sync_prev resets high, so a line held high through reset is not taken as a start edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      sync_prev <= 1'b1;
    end else begin
      sync1     <= in;
      sync2     <= sync1;
      sync_prev <= sync2;
    end
  end

  assign rise = sync2 & ~sync_prev;

`ifdef DEFRAMER_MAJORITY_EN
  logic sync_prev2;

  // Keeps a third sample so the vote can cover the nominal point -1, 0 and +1.
  always_ff @(posedge clk) begin
    if (reset) sync_prev2 <= 1'b0;
    else       sync_prev2 <= sync_prev;
  end

  assign sample_bit = (sync2 & sync_prev) | (sync2 & sync_prev2) | (sync_prev & sync_prev2);
`else
  assign sample_bit = sync2;
`endif

  // FSM state, bit counter, shift register and the frame_err pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= 16'd0;
      idx       <= 3'd0;
      shift     <= 8'h00;
      frame_err <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      idx       <= idx_n;
      shift     <= shift_n;
      frame_err <= err_n;
    end
  end

  // Next-state logic. Each bit decision clears the counter, so the next decision comes one bit period later.
  always_comb begin
    state_n = state;
    cnt_n   = cnt + 16'd1;
    idx_n   = idx;
    shift_n = shift;
    err_n   = 1'b0;
    push    = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = 16'd0;
        if (rise) state_n = START;
      end
      START: begin
        if (cnt == START_PT) begin
          cnt_n   = 16'd0;
          idx_n   = 3'd0;
          state_n = sample_bit ? DATA : IDLE;
        end
      end
      DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_n   = 16'd0;
          shift_n = {sample_bit, shift[7:1]};
          if (idx == 3'd7) state_n = STOP;
          else             idx_n   = idx + 3'd1;
        end
      end
      STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_n = 16'd0;
          if (sample_bit) begin
            err_n   = 1'b1;
            state_n = WAIT_LOW;
          end else begin
            push    = 1'b1;
            state_n = IDLE;
          end
        end
      end
      WAIT_LOW: begin
        cnt_n = 16'd0;
        if (!sync2) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // Receive FIFO. The extra pointer bit tells full apart from empty.
  logic [7:0]  mem [FIFO_DEPTH];
  logic [PW:0] wr_ptr, rd_ptr;
  logic        empty, full, pop, wr_en;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign valid = ~empty;
  assign pop   = valid & ready;
  assign wr_en = push & (~full | pop);
  assign data  = mem[rd_ptr[PW-1:0]];

  // FIFO storage, pointers and the sticky overflow flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= 8'h00;
    end else begin
      if (wr_en) begin
        mem[wr_ptr[PW-1:0]] <= shift;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !wr_en) overflow <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_delay_line_deframer.sv
// ============================================================================
// Module     : tb_delay_line_deframer
// Description: Scoreboard testbench for delay_line_deframer. It drives directed
//              frames, and a monitor compares each popped byte with the queue.
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_delay_line_deframer;

  localparam int B = 154;

  logic       clk = 1'b0;
  logic       reset, in, ready;
  logic [7:0] data;
  logic       valid, frame_err, overflow, busy;

  logic [7:0] exp_q[$];
  logic [7:0] exp_b;
  int checks = 0, failures = 0;
  int err_seen = 0, valid_cycles = 0;
  int e0, v0, waited;

  delay_line_deframer #(.BIT_CYCLES(B), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .in(in), .data(data), .valid(valid),
    .ready(ready), .frame_err(frame_err), .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  // Monitor: pops the scoreboard for every accepted byte.
  always @(negedge clk) begin
    if (!reset) begin
      if (frame_err) err_seen++;
      if (valid) valid_cycles++;
      if (valid && ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL pop_unexpected: got data=%02h, required no output", data);
        end else begin
          exp_b = exp_q.pop_front();
          if (data !== exp_b) begin
            failures++;
            $display("FAIL pop_data: got %02h, required %02h", data, exp_b);
          end
        end
      end
    end
  end

  task automatic check(input string name, input int actual, input int required);
    checks++;
    if (actual != required) begin
      failures++;
      $display("FAIL %s: got %0d, required %0d", name, actual, required);
    end
  endtask

  task automatic hold_bit(input logic v, input int n);
    in = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Sends a full frame. glitch_bit selects a data bit whose line sample point gets a one-cycle inversion.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int glitch_bit);
    hold_bit(1'b1, B);
    for (int i = 0; i < 8; i++) begin
      if (i == glitch_bit) begin
        hold_bit(b[i], 78);
        hold_bit(~b[i], 1);
        hold_bit(b[i], 75);
      end else begin
        hold_bit(b[i], B);
      end
    end
    hold_bit(stop, B);
  endtask

  initial begin
    reset = 1'b1; in = 1'b0; ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_valid", valid, 0);
    check("reset_data", data, 8'h00);
    check("reset_busy", busy, 0);
    check("reset_overflow", overflow, 0);
    check("reset_frame_err", frame_err, 0);
    reset = 1'b0;
    hold_bit(1'b0, 10);

    // Single good frame
    v0 = valid_cycles; e0 = err_seen;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b0, -1);
    hold_bit(1'b0, 20);
    check("a5_valid_cycles", valid_cycles - v0, 1);
    check("a5_frame_err", err_seen - e0, 0);
    check("a5_overflow", overflow, 0);

    // Short high pulse is rejected as a glitch
    v0 = valid_cycles; e0 = err_seen;
    hold_bit(1'b1, 40);
    in = 1'b0;
    waited = 0;
    while (busy && waited < 80) begin
      @(posedge clk); #1;
      waited++;
    end
    check("glitch_busy_clear", busy, 0);
    hold_bit(1'b0, 20);
    check("glitch_no_valid", valid_cycles - v0, 0);
    check("glitch_no_err", err_seen - e0, 0);

    // Bad stop bit
    v0 = valid_cycles; e0 = err_seen;
    send_frame(8'h3C, 1'b1, -1);
    hold_bit(1'b1, 100);
    check("stop_err_pulse", err_seen - e0, 1);
    check("stop_busy_wait", busy, 1);
    hold_bit(1'b0, 6);
    check("stop_busy_clear", busy, 0);
    check("stop_no_valid", valid_cycles - v0, 0);

    // Overflow: five frames with ready low
    ready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      if (k <= 4) exp_q.push_back(8'(k));
      send_frame(8'(k), 1'b0, -1);
    end
    hold_bit(1'b0, 10);
    check("ovf_flag", overflow, 1);
    check("ovf_valid_held", valid, 1);
    check("ovf_head_stable", data, 8'h01);
    ready = 1'b1;
    hold_bit(1'b0, 10);
    check("ovf_drained_valid", valid, 0);
    check("ovf_queue_empty", exp_q.size(), 0);
    check("ovf_sticky", overflow, 1);

    // Reset during bit 4 abandons the frame
    hold_bit(1'b1, B);
    for (int i = 0; i < 4; i++) hold_bit(((8'h7E >> i) & 8'h01) != 0, B);
    hold_bit(1'b1, 50);
    reset = 1'b1; in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_mid_valid", valid, 0);
    check("rst_mid_data", data, 8'h00);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_overflow", overflow, 0);
    check("rst_mid_frame_err", frame_err, 0);
    reset = 1'b0;
    hold_bit(1'b0, 10);
    v0 = valid_cycles;
    exp_q.push_back(8'h7E);
    send_frame(8'h7E, 1'b0, -1);
    hold_bit(1'b0, 20);
    check("rst_7e_valid_cycles", valid_cycles - v0, 1);

    // One-cycle glitch at the sample point of bit 3
`ifdef DEFRAMER_MAJORITY_EN
    exp_q.push_back(8'h55);
`else
    exp_q.push_back(8'h5D);
`endif
    send_frame(8'h55, 1'b0, 3);
    hold_bit(1'b0, 20);
    check("final_queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/delay_line_deframer.md
DELAY_LINE_DEFRAMER -- requirements
Module: delay_line_deframer

Interface
REQ-001 The block SHALL have parameter BIT_CYCLES, default 154, meaning clk cycles per line bit (1.9 us at 81 MHz); legal range 8 to 65535.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4, meaning the number of received bytes held; the value SHALL be a power of two, 2 to 16.
REQ-003 Port clk, input, 1: the single system clock (81 MHz PLL output); all logic is on its rising edge.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Port in, input, 1: asynchronous serial stream returned from the delay line.
REQ-006 Port data, output, 8: head-of-FIFO byte.
REQ-007 Port valid, output, 1: data holds a received byte.
REQ-008 Port ready, input, 1: the consumer accepts data in this cycle.
REQ-009 Port frame_err, output, 1: one-cycle pulse when a frame has a bad stop bit.
REQ-010 Port overflow, output, 1: sticky flag; a byte was dropped because the FIFO was full.
REQ-011 Port busy, output, 1: the FSM is not in IDLE.

Function
REQ-012 Line format SHALL be: idle low, start bit 1, 8 data bits LSB first, stop bit 0, each bit BIT_CYCLES long.
REQ-013 in SHALL pass through a 2-flop synchronizer; all decisions SHALL use the synchronized value (2-cycle latency).
REQ-014 The FSM SHALL have states IDLE, START, DATA, STOP and WAIT_LOW.
REQ-015 IDLE -> START SHALL occur on a synchronized 0->1 edge; the bit counter SHALL clear.
REQ-016 In START, the block SHALL sample at count BIT_CYCLES/2 (integer division): 0 -> IDLE with no output (glitch reject); 1 -> DATA with the counter cleared.
REQ-017 In DATA, the block SHALL sample every BIT_CYCLES cycles into bit index 0..7, then go to STOP after bit 7.
REQ-018 In STOP, after BIT_CYCLES cycles, a sample of 0 SHALL push the byte and go to IDLE; a sample of 1 SHALL pulse frame_err, discard the byte and go to WAIT_LOW.
REQ-019 WAIT_LOW -> IDLE SHALL occur when the synchronized input is 0.
REQ-020 A pushed byte SHALL appear at valid/data on the cycle after the stop-bit sample when the FIFO was empty.
REQ-021 valid SHALL be high whenever the FIFO is non-empty; a pop SHALL occur when valid and ready are both high.
REQ-022 data SHALL stay stable while valid is high and ready is low.
REQ-023 A push to a full FIFO SHALL be accepted if a pop occurs in the same cycle; otherwise the byte SHALL be dropped and overflow set.
REQ-024 A simultaneous push and pop on an empty FIFO SHALL leave valid high with the new byte on the next cycle.
REQ-025 overflow SHALL clear only on reset.
REQ-026 FIFO pointers SHALL wrap modulo FIFO_DEPTH, with full and empty distinguished by an extra pointer bit.

Reset
REQ-027 While reset is high at a rising clk edge, the block SHALL take: FSM IDLE, counters 0, synchronizer flops 0, FIFO empty, data 8'h00, valid 0, frame_err 0, overflow 0, busy 0.
REQ-028 Reset asserted mid-frame SHALL abandon the frame; the block SHALL detect a start edge only after the synchronized input has been low for at least one cycle after reset.

Configuration
REQ-029 Macro DEFRAMER_MAJORITY_EN SHALL control bit sampling.
REQ-030 With DEFRAMER_MAJORITY_EN defined, every bit sample (start, data, stop) SHALL be the 2-of-3 majority of samples at the nominal count -1, 0 and +1, decided at +1; all later timing SHALL shift by 1 cycle.
REQ-031 Without DEFRAMER_MAJORITY_EN, each bit sample SHALL be a single sample at the nominal count.

Verification
REQ-032 Reset, then frame 0xA5 with ready=1 -> exactly one valid cycle with data=0xA5, frame_err=0, overflow=0.
REQ-033 40-cycle high pulse on in -> no valid and no frame_err; busy returns to 0 within 80 cycles.
REQ-034 Frame 0x3C with stop bit 1 -> one-cycle frame_err pulse, no valid, busy=1 until in goes low.
REQ-035 Five frames 0x01..0x05 with ready=0, then ready=1 -> overflow=1; pops yield 0x01..0x04 in order, then valid=0.
REQ-036 reset asserted during bit 4 of a frame -> all outputs at reset values; the next 0x7E frame is received correctly.
REQ-037 With DEFRAMER_MAJORITY_EN, a 1-cycle inverted glitch at the mid-point of bit 3 of 0x55 -> data=0x55; without the macro -> data=0x5D.
